// File: rtl/krz_spram_arbiter.sv
// Two-master Wishbone arbiter in front of the shared main-memory SPRAM bank.
// Each transfer takes an address cycle (IDLE) and an ack cycle (ACK).
module krz_spram_arbiter #(
    parameter int AW         = 15,
    parameter int ARB_MODE   = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] instr_adr,
    input  logic          instr_stb,
    output logic [31:0]   instr_dat,
    output logic          instr_ack,

    input  logic [AW-1:0] data_adr,
    input  logic [31:0]   data_dat_w,
    input  logic [3:0]    data_sel,
    input  logic          data_we,
    input  logic          data_stb,
    output logic [31:0]   data_dat_r,
    output logic          data_ack,

    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wmask,
    output logic          mem_we,
    output logic          mem_cs,
    input  logic [31:0]   mem_rdata
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    localparam logic G_INSTR = 1'b0;
    localparam logic G_DATA  = 1'b1;

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic [0:0]    state;
    logic          grant;
    logic          last_grant;
    logic [CW-1:0] starve_cnt;

    logic          req;
    logic          accept;
    logic          data_pref;
    logic          win_d;

    always_comb begin
        req    = instr_stb | data_stb;
        accept = (state == S_IDLE) & req;
        if (ARB_MODE == 0) begin
            data_pref = (last_grant == G_INSTR);
        end else begin
            data_pref = (starve_cnt != SMAX);
        end
        // a lone requester always wins; the preference only breaks ties
        win_d = data_stb & (~instr_stb | data_pref);
    end

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (accept) begin
            mem_cs = 1'b1;
            if (win_d) begin
                mem_addr = data_adr;
                if (data_we) begin
                    mem_we    = 1'b1;
                    mem_wdata = data_dat_w;
                    mem_wmask = data_sel;
                end
            end else begin
                mem_addr = instr_adr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= G_INSTR;
            last_grant <= G_INSTR;
        end else begin
            if (state == S_IDLE) begin
                if (req) begin
                    state      <= S_ACK;
                    grant      <= win_d;
                    last_grant <= win_d;
                end
            end else begin
                state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (ARB_MODE != 0 && state == S_IDLE) begin
            if (!instr_stb) begin
                starve_cnt <= '0;
            end else if (!win_d) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SMAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        instr_ack  = (state == S_ACK) & (grant == G_INSTR);
        data_ack   = (state == S_ACK) & (grant == G_DATA);
        instr_dat  = instr_ack ? mem_rdata : 32'h0;
        data_dat_r = data_ack ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_krz_spram_arbiter.sv
// Bench for krz_spram_arbiter: one round-robin and one data-priority instance
// share stimulus; each has its own SPRAM model and expected-ack queue.
module tb_krz_spram_arbiter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] instr_adr = '0;
    logic          instr_stb = 1'b0;
    logic [AW-1:0] data_adr = '0;
    logic [31:0]   data_dat_w = '0;
    logic [3:0]    data_sel = '0;
    logic          data_we = 1'b0;
    logic          data_stb = 1'b0;

    logic [31:0]   instr_dat0, instr_dat1, data_dat_r0, data_dat_r1;
    logic          instr_ack0, instr_ack1, data_ack0, data_ack1;
    logic [AW-1:0] mem_addr0, mem_addr1;
    logic [31:0]   mem_wdata0, mem_wdata1;
    logic [3:0]    mem_wmask0, mem_wmask1;
    logic          mem_we0, mem_we1, mem_cs0, mem_cs1;
    logic [31:0]   mem_rdata0 = '0, mem_rdata1 = '0;

    logic [31:0]   ram0 [0:255];
    logic [31:0]   ram1 [0:255];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        bit          d;
        bit          chkd;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    krz_spram_arbiter #(.AW(AW), .ARB_MODE(0), .STARVE_MAX(4)) u_rr (
        .clk(clk), .rst(rst),
        .instr_adr(instr_adr), .instr_stb(instr_stb),
        .instr_dat(instr_dat0), .instr_ack(instr_ack0),
        .data_adr(data_adr), .data_dat_w(data_dat_w), .data_sel(data_sel),
        .data_we(data_we), .data_stb(data_stb),
        .data_dat_r(data_dat_r0), .data_ack(data_ack0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_wmask(mem_wmask0),
        .mem_we(mem_we0), .mem_cs(mem_cs0), .mem_rdata(mem_rdata0)
    );

    krz_spram_arbiter #(.AW(AW), .ARB_MODE(1), .STARVE_MAX(4)) u_pr (
        .clk(clk), .rst(rst),
        .instr_adr(instr_adr), .instr_stb(instr_stb),
        .instr_dat(instr_dat1), .instr_ack(instr_ack1),
        .data_adr(data_adr), .data_dat_w(data_dat_w), .data_sel(data_sel),
        .data_we(data_we), .data_stb(data_stb),
        .data_dat_r(data_dat_r1), .data_ack(data_ack1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1),
        .mem_we(mem_we1), .mem_cs(mem_cs1), .mem_rdata(mem_rdata1)
    );

    always @(posedge clk) begin
        if (mem_cs0) begin
            if (mem_we0) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask0[b])
                        ram0[mem_addr0[7:0]][8*b +: 8] <= mem_wdata0[8*b +: 8];
            end else begin
                mem_rdata0 <= ram0[mem_addr0[7:0]];
            end
        end
        if (mem_cs1) begin
            if (mem_we1) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask1[b])
                        ram1[mem_addr1[7:0]][8*b +: 8] <= mem_wdata1[8*b +: 8];
            end else begin
                mem_rdata1 <= ram1[mem_addr1[7:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input bit d, input bit chkd,
                        input logic [31:0] dat, input int c);
        exp_t e;
        e.d = d;
        e.chkd = chkd;
        e.dat = dat;
        e.cyc = c;
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon(input int id, input logic ia, input logic da,
                       input logic [31:0] idat, input logic [31:0] ddat);
        exp_t e;
        int n;
        if (ia | da) begin
            check($sformatf("excl%0d", id), 64'(ia & da), 64'h0);
            n = (id == 0) ? q0.size() : q1.size();
            check($sformatf("ack_expected%0d", id), 64'(n != 0), 64'h1);
            if (n != 0) begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("port%0d", id), 64'(da), 64'(e.d));
                if (e.chkd)
                    check($sformatf("rdata%0d", id), da ? ddat : idat, e.dat);
                check($sformatf("ack_cyc%0d", id), 64'(cyc), 64'(e.cyc));
            end
        end else begin
            check($sformatf("idle_dat%0d", id), {idat, ddat}, 64'h0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, instr_ack0, data_ack0, instr_dat0, data_dat_r0);
            mon(1, instr_ack1, data_ack1, instr_dat1, data_dat_r1);
        end
    end

    task automatic chk_quiet(input string tag);
        check({tag, "_ctl"}, 64'({instr_ack0, data_ack0, mem_cs0, mem_we0,
                                  instr_ack1, data_ack1, mem_cs1, mem_we1}), 64'h0);
        check({tag, "_bus0"}, {mem_addr0, mem_wmask0, mem_wdata0}, 64'h0);
        check({tag, "_bus1"}, {mem_addr1, mem_wmask1, mem_wdata1}, 64'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int c0;
        int c1;
        bit ds [6];
        bit dp [6];
        ds = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        dp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 256; i++) begin
            ram0[i] = 32'h0;
            ram1[i] = 32'h0;
        end
        ram0[8'h10] = 32'hDEADBEEF; ram1[8'h10] = 32'hDEADBEEF;
        ram0[8'h20] = 32'hAAAAAAAA; ram1[8'h20] = 32'hAAAAAAAA;
        ram0[8'h40] = 32'hC0DE0040; ram1[8'h40] = 32'hC0DE0040;
        ram0[8'h41] = 32'hDA7A0041; ram1[8'h41] = 32'hDA7A0041;

        @(negedge clk);
        chk_quiet("in_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("after_reset");

        // instruction read alone
        @(posedge clk);
        #1 instr_adr = 15'h10;
        instr_stb = 1'b1;
        t0 = cyc;
        push(0, 1'b0, 1'b1, 32'hDEADBEEF, t0 + 1);
        push(1, 1'b0, 1'b1, 32'hDEADBEEF, t0 + 1);
        @(negedge clk);
        check("ird_cs", 64'({mem_cs0, mem_cs1, mem_we0, mem_we1}), 64'hC);
        check("ird_addr0", 64'(mem_addr0), 64'h10);
        check("ird_addr1", 64'(mem_addr1), 64'h10);
        @(posedge clk);
        #1 instr_stb = 1'b0;
        @(posedge clk);

        // byte write then read back
        #1 data_adr = 15'h20;
        data_dat_w = 32'h11223344;
        data_sel = 4'b0010;
        data_we = 1'b1;
        data_stb = 1'b1;
        t0 = cyc;
        push(0, 1'b1, 1'b0, 32'h0, t0 + 1);
        push(1, 1'b1, 1'b0, 32'h0, t0 + 1);
        @(negedge clk);
        check("wr_ctl", 64'({mem_cs0, mem_we0, mem_cs1, mem_we1}), 64'hF);
        check("wr_mask", 64'({mem_wmask0, mem_wmask1}), 64'h22);
        check("wr_data0", 64'(mem_wdata0), 64'h11223344);
        check("wr_addr1", 64'(mem_addr1), 64'h20);
        @(posedge clk);
        #1 data_stb = 1'b0;
        data_we = 1'b0;
        @(posedge clk);
        #1 data_stb = 1'b1;
        t0 = cyc;
        push(0, 1'b1, 1'b1, 32'hAAAA33AA, t0 + 1);
        push(1, 1'b1, 1'b1, 32'hAAAA33AA, t0 + 1);
        @(negedge clk);
        check("rd_we", 64'({mem_cs0, mem_we0, mem_cs1, mem_we1}), 64'hA);
        @(posedge clk);
        #1 data_stb = 1'b0;
        @(posedge clk);

        // stb held through ack: three back-to-back transfers
        #1 instr_adr = 15'h10;
        instr_stb = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            push(0, 1'b0, 1'b1, 32'hDEADBEEF, t0 + 1 + 2 * k);
            push(1, 1'b0, 1'b1, 32'hDEADBEEF, t0 + 1 + 2 * k);
        end
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c0 += int'(mem_cs0);
            c1 += int'(mem_cs1);
        end
        check("held_cs0", 64'(c0), 64'd3);
        check("held_cs1", 64'(c1), 64'd3);
        @(posedge clk);
        #1 instr_stb = 1'b0;
        @(posedge clk);

        // reset during the ack cycle of a data read
        #1 data_adr = 15'h41;
        data_stb = 1'b1;
        @(posedge clk);
        #1 data_stb = 1'b0;
        #1 rst = 1'b1;
        #1 check("rst_ack", 64'({data_ack0, data_ack1, instr_ack0, instr_ack1}), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_cs", 64'({mem_cs0, mem_cs1}), 64'h0);
        @(posedge clk);
        #1 instr_adr = 15'h40;
        data_adr = 15'h41;
        instr_stb = 1'b1;
        data_stb = 1'b1;
        t0 = cyc;
        push(0, 1'b1, 1'b1, 32'hDA7A0041, t0 + 1);
        push(1, 1'b1, 1'b1, 32'hDA7A0041, t0 + 1);
        @(posedge clk);
        #1 instr_stb = 1'b0;
        data_stb = 1'b0;

        // sustained contention from reset
        do_reset();
        @(posedge clk);
        #1 instr_adr = 15'h40;
        data_adr = 15'h41;
        instr_stb = 1'b1;
        data_stb = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 6; k++) begin
            push(0, ds[k], 1'b1, ds[k] ? 32'hDA7A0041 : 32'hC0DE0040, t0 + 1 + 2 * k);
            push(1, dp[k], 1'b1, dp[k] ? 32'hDA7A0041 : 32'hC0DE0040, t0 + 1 + 2 * k);
        end
        repeat (12) @(posedge clk);
        #1 instr_stb = 1'b0;
        data_stb = 1'b0;

        repeat (4) @(posedge clk);
        #1 check("q0_left", 64'(q0.size()), 64'h0);
        check("q1_left", 64'(q1.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/krz_spram_arbiter.md
Name: krz_spram_arbiter

Overview:
- Shares the single-port main-memory SPRAM bank (two 16-bit SPRAM macros forming one 32-bit word) between the core's instruction and data Wishbone (classic) buses.
- Sits in krz_top between the core and the memory bank.
- Serialises requests, drives the SRAM control, and returns read data and ack to the granted master.
- One transfer per two cycles; the arbitration policy is selectable.

Parameters:
- AW, 15, word address width of the SRAM bank (32K words).
- ARB_MODE, 0, 0 = round-robin, 1 = data-port priority with starvation limit.
- STARVE_MAX, 4, ARB_MODE=1 only: consecutive data grants allowed while the instruction port waits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- instr_adr  in  AW  instruction word address
- instr_stb  in  1  instruction request
- instr_dat  out  32  instruction read data, valid with instr_ack
- instr_ack  out  1  instruction transfer complete
- data_adr  in  AW  data word address
- data_dat_w  in  32  write data
- data_sel  in  4  byte enables
- data_we  in  1  1 = write
- data_stb  in  1  data request
- data_dat_r  out  32  data read data, valid with data_ack
- data_ack  out  1  data transfer complete
- mem_addr  out  AW  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_wmask  out  4  SRAM byte write mask
- mem_we  out  1  SRAM write enable
- mem_cs  out  1  SRAM chip select
- mem_rdata  in  32  SRAM read data, valid the cycle after a read access

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: FSM in IDLE; instr_ack, data_ack, mem_cs and mem_we are 0; mem_addr, mem_wdata and mem_wmask are 0; last_grant = INSTR; starve_cnt = 0.
- FSM IDLE:
  - If any stb is high, select a winner per policy.
  - Drive mem_cs=1 and mem_addr from the winner's address (combinational from the inputs, same cycle).
  - For a data write, also drive mem_we=1, mem_wdata=data_dat_w, mem_wmask=data_sel.
  - Go to ACK with grant latched.
- FSM ACK:
  - Assert exactly the granted port's ack for this one cycle.
  - Read data: instr_dat or data_dat_r equals mem_rdata, passed through unregistered.
  - mem_cs=0 and mem_we=0; always return to IDLE.
  - No new request is accepted in ACK. A master holding stb high through its ack cycle is treated as a new request in the next IDLE.
- Latency: request seen in IDLE at cycle N -> ack at cycle N+1. Peak throughput is one transfer per two cycles.
- Outside their ack cycle, instr_dat and data_dat_r are 0.
- Round-robin (ARB_MODE=0):
  - Single requester always wins.
  - On contention, the port not equal to last_grant wins.
  - last_grant updates on every grant.
- Data priority (ARB_MODE=1):
  - On contention, data wins unless starve_cnt == STARVE_MAX, in which case instruction wins.
  - starve_cnt increments on each data grant while instr_stb is high, saturating at STARVE_MAX.
  - starve_cnt clears on any instruction grant, or when instr_stb is low in IDLE.
- A stb dropped before grant is simply not served; no ack is ever issued to a non-granted port.
- A write never produces an instr_ack.
- Address is used unchanged (no range check); wrap-around is the SRAM's responsibility.
- Reset mid-ACK: the ack is suppressed immediately (async) and the FSM restarts in IDLE. The master must re-issue.
- Both acks high simultaneously is illegal; the verification engineer asserts instr_ack & data_ack == 0 every cycle.

Test Plan:
- Instr read alone: mem preloaded word 0x10 = 0xDEADBEEF; instr_adr=0x10, instr_stb=1 -> mem_cs=1 in cycle 0; instr_ack=1 with instr_dat=0xDEADBEEF in cycle 1; data_ack stays 0.
- Data byte write then read: data_adr=0x20, data_dat_w=0x11223344, data_sel=4'b0010, data_we=1 on a word holding 0xAAAAAAAA -> mem_wmask=4'b0010; data_ack at +1. A subsequent read returns 0xAAAA33AA.
- Round-robin contention (ARB_MODE=0): both stb held high for 8 cycles after reset -> grant order D, I, D, I; acks alternate every 2 cycles, 4 total.
- Priority starvation (ARB_MODE=1, STARVE_MAX=4): both stb held high -> grant order D, D, D, D, I, D, ...; instr_ack first at cycle 9 after the request start.
- Reset mid-operation: assert rst during the ACK cycle of a data read -> data_ack drops in the same cycle; after release with no stb, mem_cs=0; the next contended grant goes to data.
- Stb held through ack: instr_stb held high at a constant address for 6 cycles -> exactly 3 instr_acks, each separated by one idle cycle, and mem_cs pulses 3 times.
